// File: rtl/snn_mac_scheduler.sv
// Spiking-neuron timestep scheduler: feeds NGROUP spike/weight groups to an external
// MAC, accumulates the tagged results, then applies leak, saturation and threshold.
module snn_mac_scheduler #(
  parameter int S      = 5,
  parameter int WIDTH  = 8,
  parameter int NGROUP = 4,
  parameter int LAT    = 3,
  parameter int VW     = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic signed [VW-1:0]        thresh,
  input  logic [2:0]                  leak_shift,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [S-1:0]                in_spikes,
  output logic [$clog2(NGROUP)-1:0]   w_addr,
  input  logic [S*WIDTH-1:0]          w_data,
  output logic [S-1:0]                mac_pixels,
  output logic [S*WIDTH-1:0]          mac_weights,
  input  logic signed [WIDTH+2:0]     mac_sum,
  output logic signed [VW-1:0]        vmem,
  output logic                        spike_out,
  output logic                        spike_valid,
  output logic                        busy,
  output logic                        done,
  output logic [1:0]                  dbg_state
);

  localparam int AW  = $clog2(NGROUP);
  localparam int EXT = VW + 2 - (WIDTH + 3);
  localparam logic signed [VW+2:0] V_MAX = {4'b0000, {(VW-1){1'b1}}};
  localparam logic signed [VW+2:0] V_MIN = {4'b1111, {(VW-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FEED   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_UPDATE = 2'd3
  } state_t;

  // Handshake: a group transfers on a rising edge where in_valid and in_ready are both 1;
  // in_ready is registered and high only in FEED, in_valid may be held high at any time.
  state_t                  r_state;
  logic                    r_in_ready;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_spike_valid;
  logic                    r_spike_out;
  logic [AW-1:0]           r_cnt;
  logic [LAT-1:0]          r_tag;
  logic signed [VW+1:0]    r_acc;
  logic signed [VW-1:0]    r_vmem;
  logic [S-1:0]            r_pix;
  logic [S*WIDTH-1:0]      r_wts;

  logic                    w_accept;
  logic                    w_last;
  logic [LAT-1:0]          w_tag_next;
  logic signed [VW+1:0]    w_sum_ext;
  logic signed [VW+2:0]    w_vext;
  logic signed [VW+2:0]    w_leak;
  logic signed [VW+2:0]    w_acc_ext;
  logic signed [VW+2:0]    w_v;
  logic signed [VW-1:0]    w_v_sat;
  logic                    w_fire;

  assign w_accept   = in_valid & r_in_ready;
  assign w_last     = (r_cnt == AW'(NGROUP - 1));
  assign w_tag_next = {r_tag[LAT-2:0], w_accept};
  assign w_sum_ext  = {{EXT{mac_sum[WIDTH+2]}}, mac_sum};

  // Membrane update is evaluated at VW+3 bits so leak and acc can never wrap before clamping.
  assign w_vext    = {{3{r_vmem[VW-1]}}, r_vmem};
  assign w_leak    = (leak_shift == 3'd0) ? '0 : (w_vext >>> leak_shift);
  assign w_acc_ext = {r_acc[VW+1], r_acc};
  assign w_v       = w_vext - w_leak + w_acc_ext;

  always_comb begin
    w_v_sat = w_v[VW-1:0];
    if (w_v > V_MAX) begin
      w_v_sat = V_MAX[VW-1:0];
    end else if (w_v < V_MIN) begin
      w_v_sat = V_MIN[VW-1:0];
    end
  end

  assign w_fire = (w_v_sat >= thresh);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_in_ready    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_spike_valid <= 1'b0;
      r_spike_out   <= 1'b0;
      r_cnt         <= '0;
      r_tag         <= '0;
      r_acc         <= '0;
      r_vmem        <= '0;
      r_pix         <= '0;
      r_wts         <= '0;
    end else begin
      r_pix         <= w_accept ? in_spikes : '0;
      r_wts         <= w_accept ? w_data : '0;
      r_done        <= 1'b0;
      r_spike_valid <= 1'b0;
      r_tag         <= w_tag_next;
      if (r_tag[LAT-1]) begin
        r_acc <= r_acc + w_sum_ext;
      end
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state    <= ST_FEED;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_cnt      <= '0;
            r_tag      <= '0;
            r_acc      <= '0;
          end
        end
        ST_FEED: begin
          if (w_accept) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            if (w_last) begin
              r_state    <= ST_DRAIN;
              r_in_ready <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          if (r_tag == '0) begin
            r_state <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          r_vmem        <= w_fire ? '0 : w_v_sat;
          r_spike_out   <= w_fire;
          r_spike_valid <= 1'b1;
          r_done        <= 1'b1;
          r_busy        <= 1'b0;
          r_state       <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign w_addr      = r_cnt;
  assign mac_pixels  = r_pix;
  assign mac_weights = r_wts;
  assign vmem        = r_vmem;
  assign spike_out   = r_spike_out;
  assign spike_valid = r_spike_valid;
  assign busy        = r_busy;
  assign done        = r_done;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_snn_mac_scheduler.sv
// Bench for snn_mac_scheduler: a two-stage MAC model closes the loop, directed timesteps
// push expected {spike_out, vmem} and a monitor pops them on every spike_valid.
module tb_snn_mac_scheduler;

  localparam int S      = 5;
  localparam int WIDTH  = 8;
  localparam int NGROUP = 4;
  localparam int LAT    = 3;
  localparam int VW     = 16;
  localparam int AW     = $clog2(NGROUP);
  localparam logic signed [WIDTH+2:0] JUNK = 11'sd99;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b1;
  logic                     start = 1'b0;
  logic signed [VW-1:0]     thresh = 16'sd400;
  logic [2:0]               leak_shift = 3'd0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic [S-1:0]             in_spikes;
  logic [AW-1:0]            w_addr;
  logic [S*WIDTH-1:0]       w_data;
  logic [S-1:0]             mac_pixels;
  logic [S*WIDTH-1:0]       mac_weights;
  logic signed [WIDTH+2:0]  mac_sum = '0;
  logic [VW-1:0]            vmem;
  logic                     spike_out;
  logic                     spike_valid;
  logic                     busy;
  logic                     done;
  logic [1:0]               dbg_state;

  logic [S*WIDTH-1:0]       w_tab [NGROUP];
  logic [S-1:0]             s_tab [NGROUP];
  logic [VW:0]              exp_q [$];
  logic [VW:0]              mon_e;
  int                       n_cmp = 0;
  int                       n_bad = 0;
  int                       acc_cnt = 0;

  snn_mac_scheduler #(
    .S(S), .WIDTH(WIDTH), .NGROUP(NGROUP), .LAT(LAT), .VW(VW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .thresh(thresh), .leak_shift(leak_shift),
    .in_valid(in_valid), .in_ready(in_ready), .in_spikes(in_spikes),
    .w_addr(w_addr), .w_data(w_data), .mac_pixels(mac_pixels), .mac_weights(mac_weights),
    .mac_sum(mac_sum), .vmem(vmem), .spike_out(spike_out), .spike_valid(spike_valid),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // clock / reset-free clock generator
  initial forever #5 clk = ~clk;

  assign w_data    = w_tab[w_addr];
  assign in_spikes = s_tab[w_addr];

  // MAC model: input register then output register; untagged cycles return junk.
  logic [S-1:0]       m_p = '0;
  logic [S*WIDTH-1:0] m_w = '0;
  logic               t0 = 1'b0;
  logic               t1 = 1'b0;

  function automatic logic signed [WIDTH+2:0] mac_fn(input logic [S-1:0] p,
                                                     input logic [S*WIDTH-1:0] w);
    logic signed [WIDTH+2:0] sum;
    logic [WIDTH-1:0]        wl;
    sum = '0;
    for (int i = 0; i < S; i++) begin
      wl = w[(S-1-i)*WIDTH +: WIDTH];
      if (p[i]) sum = sum + {{3{wl[WIDTH-1]}}, wl};
    end
    return sum;
  endfunction

  always @(posedge clk) begin
    t0      <= in_valid && in_ready;
    m_p     <= mac_pixels;
    m_w     <= mac_weights;
    t1      <= t0;
    mac_sum <= t1 ? mac_fn(m_p, m_w) : JUNK;
    if (in_valid && in_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && spike_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got vmem %0h spike %0b expected none", vmem, spike_out);
      end else begin
        mon_e = exp_q.pop_front();
        check("spike_out", 32'(spike_out), 32'(mon_e[VW]));
        check("vmem", 32'(vmem), 32'(mon_e[VW-1:0]));
        check("done_with_valid", 32'(done), 32'd1);
      end
    end
  end

  // driver tasks
  task automatic set_tab(input logic [WIDTH-1:0] w, input logic [S-1:0] sp, input int nact);
    for (int g = 0; g < NGROUP; g++) begin
      w_tab[g] = {S{w}};
      s_tab[g] = (g < nact) ? sp : '0;
    end
  endtask

  task automatic push_exp(input logic spk, input int v);
    exp_q.push_back({spk, v[VW-1:0]});
  endtask

  task automatic run_ts(input int gap, input logic spk, input int v);
    int n;
    int a0;
    push_exp(spk, v);
    a0 = acc_cnt;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int g = 0; g < NGROUP; g++) begin
      in_valid = 1'b0;
      if (gap > 0) begin
        repeat (gap) @(negedge clk);
        check("gap_pixels", 32'(mac_pixels), 32'd0);
        check("gap_weights", 32'(|mac_weights), 32'd0);
      end
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("in_ready_feed", 32'(in_ready), 32'd1);
      check("w_addr", 32'(w_addr), 32'(g));
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("in_ready_drain", 32'(in_ready), 32'd0);
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 32'(done), 32'd1);
    check("accepts", 32'(acc_cnt - a0), 32'(NGROUP));
    @(negedge clk);
    check("pulse_width", {30'd0, done, spike_valid}, 32'd0);
  endtask

  initial begin
    int n;
    int dn;
    int a0;
    set_tab(8'h00, 5'b00000, 0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_vmem", 32'(vmem), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_done", {30'd0, done, spike_valid}, 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // all spikes, weights 0x10: acc = 4*5*16 = 320
    set_tab(8'h10, 5'b11111, NGROUP);
    run_ts(0, 1'b0, 320);
    run_ts(0, 1'b1, 0);
    run_ts(3, 1'b0, 320);

    // -55 on one lane per group: 320 - 220 = 100, then leak 100>>>2 = 25
    set_tab(8'hC9, 5'b00001, NGROUP);
    run_ts(0, 1'b0, 100);
    set_tab(8'h00, 5'b00000, NGROUP);
    leak_shift = 3'd2;
    run_ts(0, 1'b0, 75);
    leak_shift = 3'd0;

    // reset during DRAIN
    set_tab(8'h10, 5'b11111, NGROUP);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; in_valid = 1'b1;
    n = 0;
    while (dbg_state != 2'd2 && n < 40) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    check("reach_drain", 32'(dbg_state), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("async_vmem", 32'(vmem), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_state", 32'(dbg_state), 32'd0);
    check("async_mac_pix", 32'(mac_pixels), 32'd0);
    check("async_mac_wts", 32'(|mac_weights), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_tab(8'h08, 5'b00001, 1);
    run_ts(0, 1'b0, 8);

    // positive saturation: 12 x 2540, then 2220, then clamp to 32767 and fire
    thresh = 16'sd32767;
    set_tab(8'h7F, 5'b11111, NGROUP);
    for (int k = 1; k <= 12; k++) run_ts(0, 1'b0, 8 + 2540 * k);
    set_tab(8'h6F, 5'b11111, NGROUP);
    run_ts(0, 1'b0, 32708);
    set_tab(8'h7F, 5'b11111, NGROUP);
    run_ts(0, 1'b1, 0);

    // negative saturation: steps of -2560 clamp at -32768
    set_tab(8'h80, 5'b11111, NGROUP);
    for (int k = 1; k <= 12; k++) run_ts(0, 1'b0, -2560 * k);
    run_ts(0, 1'b0, -32768);
    run_ts(0, 1'b0, -32768);

    // start and in_valid held high: three back-to-back timesteps
    set_tab(8'h10, 5'b11111, NGROUP);
    push_exp(1'b0, -32448);
    push_exp(1'b0, -32128);
    push_exp(1'b0, -31808);
    a0 = acc_cnt;
    dn = 0;
    n = 0;
    @(negedge clk); start = 1'b1; in_valid = 1'b1;
    while (dn < 3 && n < 300) begin
      @(negedge clk);
      n++;
      if (done) begin
        dn++;
        check("busy_at_done", 32'(busy), 32'd0);
        if (dn == 3) begin
          start = 1'b0;
          in_valid = 1'b0;
        end
      end
    end
    check("b2b_done_count", 32'(dn), 32'd3);
    check("b2b_accepts", 32'(acc_cnt - a0), 32'(3 * NGROUP));
    repeat (4) @(negedge clk);
    check("b2b_idle", 32'(dbg_state), 32'd0);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/snn_mac_scheduler.md
SNN_MAC_SCHEDULER -- requirements
Module: snn_mac_scheduler

Interface
REQ-001 SHALL have parameter S, default 5: spike inputs and weight lanes per MAC group.
REQ-002 SHALL have parameter WIDTH, default 8: weight width, signed Q1.7.
REQ-003 SHALL have parameter NGROUP, default 4: MAC groups per timestep, 2..16.
REQ-004 SHALL have parameter LAT, default 3: edges from group accept to mac_sum valid; covers the scheduler output register, MAC input register and MAC output register.
REQ-005 SHALL have parameter VW, default 16: membrane width, signed.
REQ-006 SHALL have clk, input, 1: single clock, all state on rising edge.
REQ-007 SHALL have rst_n, input, 1: reset, asynchronous and active-low.
REQ-008 SHALL have start, input, 1: begin one timestep; honoured only in IDLE.
REQ-009 SHALL have thresh, input, VW: firing threshold, signed.
REQ-010 SHALL have leak_shift, input, 3: leak = vmem>>>leak_shift; 0 = no leak.
REQ-011 SHALL have in_valid / in_ready, input / output, 1 each: spike-group handshake.
REQ-012 SHALL have in_spikes, input, S: binary spikes of current group.
REQ-013 SHALL have w_addr, output, clog2(NGROUP): group index; w_data, input, S*WIDTH: weights, combinational for w_addr, lane 0 in MSBs.
REQ-014 SHALL have mac_pixels, output, S, and mac_weights, output, S*WIDTH: registered MAC operands.
REQ-015 SHALL have mac_sum, input, WIDTH+3: MAC result, signed two's complement.
REQ-016 SHALL have vmem, output, VW; spike_out, output, 1; spike_valid, output, 1; busy, output, 1; done, output, 1.

Function
REQ-017 SHALL implement FSM IDLE -> FEED -> DRAIN -> UPDATE -> IDLE.
REQ-018 IDLE: busy=0, in_ready=0; start=1 SHALL clear acc, group counter and pipeline tags, and go to FEED.
REQ-019 FEED: in_ready=1, w_addr=group counter; an accept (in_valid&in_ready) SHALL register in_spikes and w_data into mac_pixels/mac_weights and increment the counter.
REQ-020 Cycles in FEED without an accept SHALL load mac_pixels=0 and mac_weights=0.
REQ-021 The NGROUP-th accept SHALL move to DRAIN; in_ready SHALL be 0 outside FEED.
REQ-022 SHALL keep a LAT-deep valid-tag shift register; a tag set at an accept SHALL cause acc += sign-extended mac_sum exactly LAT edges later; untagged mac_sum SHALL be ignored.
REQ-023 DRAIN SHALL last until all tags are clear, then go to UPDATE.
REQ-024 acc SHALL be VW+2 bits signed; no overflow is possible for NGROUP<=16.
REQ-025 UPDATE (one cycle): v = vmem - leak + acc, computed at VW+3 bits and then saturated to [-2^(VW-1), 2^(VW-1)-1].
REQ-026 If v >= thresh (signed): spike_out=1, vmem=0; else spike_out=0, vmem=v. spike_valid=1 and done=1 for exactly that edge's following cycle.
REQ-027 spike_out SHALL hold its value until the next UPDATE; vmem SHALL persist across timesteps.
REQ-028 start while busy SHALL be ignored; in_valid outside FEED SHALL be ignored.
REQ-029 thresh and leak_shift SHALL be sampled only in UPDATE.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE and clear vmem, acc, counter, tags, mac_pixels, mac_weights, spike_out, spike_valid, done, busy and in_ready to 0, including mid-timestep.
REQ-031 After rst_n rises, no accumulation from pre-reset pipeline contents SHALL occur.

Verification
REQ-032 All 4 groups in_spikes=5'b11111, weights all 0x10, mac_sum driven by a MAC model, thresh=400, leak_shift=0 -> acc=320, vmem=320, spike_out=0; repeat timestep -> v=640, spike_out=1, vmem=0.
REQ-033 in_valid deasserted 3 cycles between groups -> identical acc to back-to-back feed; exactly 4 accepts; mac_sum samples during gaps are ignored.
REQ-034 vmem=100, acc=0, leak_shift=2 -> vmem=75, spike_valid one cycle, done one cycle.
REQ-035 Weights all 0x7F, all spikes, vmem=32700, thresh=32767 -> saturates to 32767 and fires; negative case with 0x80 weights -> vmem clamps at -32768.
REQ-036 rst_n pulsed low during DRAIN -> outputs 0 asynchronously; next timestep with 1 group of weight 0x08 and spike on lane 0 only -> vmem=8.
REQ-037 start held high continuously -> timesteps run back-to-back with no overlap; each timestep gives one done pulse.
